// File: rtl/m_ext_pkg.sv
// Shared M-extension types and constants used by the decode stage and the divider.
package m_ext_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/divider_iterative.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a start/done handshake.
module divider_iterative
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result_divide
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN_X = XLEN'(INT_MIN);
  localparam logic [XLEN-1:0] DBZ_Q_X   = XLEN'(DIV_BY_ZERO_Q);

  div_state_t        state_reg, state_next;
  div_op_t           op_reg;
  logic              is_signed_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic [XLEN-1:0]   dividend_reg;
  logic [XLEN-1:0]   divisor_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   result_reg;

  logic              is_rem;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   abs_dividend;
  logic [XLEN-1:0]   abs_divisor;
  logic [XLEN:0]     rem_wide;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign is_rem   = (op_reg == REM) || (op_reg == REMU);
  // Evaluated in PREP while dividend_reg/divisor_reg still hold the raw operands.
  assign div_zero = (divisor_reg == '0);
  assign overflow = is_signed_reg && (dividend_reg == INT_MIN_X) && (divisor_reg == '1);

  assign abs_dividend = (is_signed_reg && dividend_reg[XLEN-1]) ? -dividend_reg : dividend_reg;
  assign abs_divisor  = (is_signed_reg && divisor_reg[XLEN-1])  ? -divisor_reg  : divisor_reg;

  // The remainder keeps the bit shifted out of the top so 2*rem cannot overflow XLEN bits.
  assign rem_wide = acc_reg[2*XLEN-1:XLEN-1];
  assign trial    = rem_wide - {1'b0, divisor_reg};
  assign step_rem = trial[XLEN] ? rem_wide[XLEN-1:0] : trial[XLEN-1:0];

  assign quo_fix = q_neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_fix = r_neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  assign result_divide = result_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = PREP;
      end
      PREP: state_next = (div_zero || overflow) ? DONE : CALC;
      CALC: if (cnt_reg == CNT_LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= DIV;
      is_signed_reg <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg        <= div_op_t'(div_opcode);
            is_signed_reg <= ~div_opcode[0];
            q_neg_reg     <= ~div_opcode[0] & (operand1[XLEN-1] ^ operand2[XLEN-1]);
            r_neg_reg     <= ~div_opcode[0] & operand1[XLEN-1];
            dividend_reg  <= operand1;
            divisor_reg   <= operand2;
          end
        end
        PREP: begin
          cnt_reg     <= '0;
          acc_reg     <= {{XLEN{1'b0}}, abs_dividend};
          divisor_reg <= abs_divisor;
          if (div_zero) begin
            result_reg <= is_rem ? dividend_reg : DBZ_Q_X;
          end else if (overflow) begin
            result_reg <= is_rem ? '0 : INT_MIN_X;
          end
        end
        CALC: begin
          acc_reg <= {step_rem, acc_reg[XLEN-2:0], ~trial[XLEN]};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: result_reg <= is_rem ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_iterative.md
# divider_iterative

Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits directly downstream of the execute-stage M-extension decode block and takes its operand1, operand2 and div_opcode outputs. Replaces the single-cycle combinational divider with a start/done handshake that matches the iterative multiplier, so both M-extension units stall the pipeline the same way.

## Interface
Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- div_opcode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
- operand1  input  XLEN  dividend; sampled with start.
- operand2  input  XLEN  divisor; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done, inclusive.
- done  output  1  one-cycle pulse; result_divide is valid in this cycle.
- result_divide  output  XLEN  quotient or remainder; held until the next accepted start.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP when start=1. Latch the opcode, the signed/unsigned flag (opcode[0]=0 means signed), the quotient sign (dividend sign XOR divisor sign, signed ops only) and the remainder sign (dividend sign, signed ops only).
- PREP: load the absolute values of the operands (raw values for unsigned ops) and clear the counter. Detect special cases, precompute their result, then go to DONE. Otherwise go to CALC.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand1.
  - Signed overflow (DIV/REM only, 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one restoring step per cycle on a 2·XLEN {rem,quo} register.
  - Shift left by 1, then trial = rem − divisor on XLEN+1 bits.
  - If trial is non-negative: rem = trial, quo[0] = 1. Otherwise quo[0] = 0.
  - The counter runs 0..XLEN−1. Go to FIX after step XLEN−1.
- FIX: negate the quotient if its sign flag is set. Negate the remainder if its sign flag is set. Select the quotient for DIV/DIVU or the remainder for REM/REMU, register it into result_divide, then go to DONE.
- DONE: done=1, busy=1, then IDLE.
- Abs/negate use two's complement. abs(0x80000000) = 0x80000000 read as unsigned, which gives the correct magnitude.

## Timing
- Reset values: state IDLE, busy 0, done 0, result_divide 0, counter 0.
- Cycle 0 is the cycle where start=1 is sampled in IDLE.
- Normal operation: PREP in cycle 1, CALC in cycles 2..33, FIX in cycle 34, done=1 in cycle 35. Total latency 35 cycles.
- Special cases: PREP in cycle 1, done=1 in cycle 2.
- start while busy is ignored; no queuing and no abort. A start in the DONE cycle is also ignored. The earliest new start is the cycle after done.
- Operand and opcode changes after cycle 0 have no effect.
- rst mid-operation returns to IDLE on the next edge, clears done/busy/result, and discards the operation.
- result_divide changes only in FIX, in the PREP→DONE special-case path, and on reset.

## Structure
- Shared package m_ext_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU = 0..3), also used by the decode stage.
  - div_state_t enum.
  - Special-case constants DIV_BY_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- Single module, no sub-module; the restoring step stays inline in the CALC arm.

## Test plan
- DIV 20 / −3 → done in cycle 35, result 0xFFFFFFFA (−6); REM same operands → 2.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU → 1; busy high cycles 1..35.
- DIV 7 / 0 → 0xFFFFFFFF; REM 7 / 0 → 7; both with done in cycle 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; done in cycle 2. DIVU with the same operands → 0 after the normal 35 cycles.
- Second start pulsed in cycle 10 with different operands → ignored; first result unchanged. Assert rst in cycle 20 of a new operation → busy=0, done never pulses, result 0.
- Random signed/unsigned sweep (≥10k ops) against a reference model with RISC-V div/rem semantics. Check that done is exactly one cycle wide and that result is held between operations.
